// File: rtl/branch_resolve.sv
// Branch resolution at commit: records branch-unit outcomes per ROB entry and,
// under a static not-taken policy, flushes and redirects fetch when a taken
// branch commits.
module branch_resolve #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PC_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [IDX_W-1:0] br_rob_index,
    input  logic [PC_W-1:0]  br_target,
    input  logic             br_taken,
    input  logic             cmt_valid,
    input  logic [IDX_W-1:0] cmt_rob_index,
    input  logic             cmt_is_branch,
    output logic             cmt_stall,
    output logic             flush,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    input  logic             redirect_ready,
    output logic [15:0]      taken_count
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    typedef enum logic [0:0] {StIdle, StRedirect} state_e;

    state_e            state_q, state_d;
    logic              flush_q, flush_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]   redirect_pc_q, redirect_pc_d;
    logic [15:0]       taken_count_q, taken_count_d;

    logic              res_q   [ENTRIES];
    logic              res_d   [ENTRIES];
    logic              taken_q [ENTRIES];
    logic              taken_d [ENTRIES];
    logic [PC_W-1:0]   tgt_q   [ENTRIES];
    logic [PC_W-1:0]   tgt_d   [ENTRIES];

    logic              commit_br;
    logic              bypass;
    logic              look_res;
    logic              look_taken;
    logic [PC_W-1:0]   look_tgt;

    // Outcome seen by the committing branch; a same-cycle result overrides the table
    always_comb begin
        commit_br  = cmt_valid & cmt_is_branch;
        bypass     = br_valid & (br_rob_index == cmt_rob_index);
        look_res   = res_q[cmt_rob_index];
        look_taken = taken_q[cmt_rob_index];
        look_tgt   = tgt_q[cmt_rob_index];
        if (bypass) begin
            look_res   = 1'b1;
            look_taken = br_taken;
            look_tgt   = br_target;
        end
    end

    // Next-state, table update and commit stall
    always_comb begin
        state_d          = state_q;
        flush_d          = 1'b0;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        taken_count_d    = taken_count_q;
        res_d            = res_q;
        taken_d          = taken_q;
        tgt_d            = tgt_q;
        cmt_stall        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (br_valid) begin
                    res_d[br_rob_index]   = 1'b1;
                    taken_d[br_rob_index] = br_taken;
                    tgt_d[br_rob_index]   = br_target;
                end
                if (commit_br) begin
                    if (!look_res) begin
                        cmt_stall = 1'b1;
                    end else if (look_taken) begin
                        // Mispredict: everything younger is squashed, so all
                        // recorded outcomes (including this cycle's) are stale.
                        flush_d          = 1'b1;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = look_tgt;
                        taken_count_d    = taken_count_q + 16'd1;
                        for (int i = 0; i < ENTRIES; i++) begin
                            res_d[i] = 1'b0;
                        end
                        state_d = StRedirect;
                    end else begin
                        // Consumed: a later write to this index may be a new branch
                        res_d[cmt_rob_index] = 1'b0;
                    end
                end
            end
            StRedirect: begin
                // Results arriving now belong to squashed work and are dropped
                cmt_stall = cmt_valid;
                if (redirect_ready) begin
                    redirect_valid_d = 1'b0;
                    state_d          = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            taken_count_q    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                res_q[i]   <= 1'b0;
                taken_q[i] <= 1'b0;
                tgt_q[i]   <= '0;
            end
        end else begin
            state_q          <= state_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            taken_count_q    <= taken_count_d;
            res_q            <= res_d;
            taken_q          <= taken_d;
            tgt_q            <= tgt_d;
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vectors, a per-ROB-entry
// outcome model checked every cycle, and literal spot checks.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic [3:0]  br_rob_index;
    logic [15:0] br_target;
    logic        br_taken;
    logic        cmt_valid;
    logic [3:0]  cmt_rob_index;
    logic        cmt_is_branch;
    logic        cmt_stall;
    logic        flush;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        redirect_ready;
    logic [15:0] taken_count;

    int checks = 0;
    int errors = 0;

    branch_resolve #(.IDX_W(4), .PC_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br_valid      (br_valid),
        .br_rob_index  (br_rob_index),
        .br_target     (br_target),
        .br_taken      (br_taken),
        .cmt_valid     (cmt_valid),
        .cmt_rob_index (cmt_rob_index),
        .cmt_is_branch (cmt_is_branch),
        .cmt_stall     (cmt_stall),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .redirect_ready(redirect_ready),
        .taken_count   (taken_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what each ROB entry's outcome is, whether a redirect is outstanding
    typedef struct packed {
        logic        res;
        logic        taken;
        logic [15:0] tgt;
    } ent_t;

    ent_t        tbl [16];
    bit          m_redir;
    bit          m_flush;
    logic [15:0] m_pc;
    logic [15:0] m_cnt;

    always @(negedge clk) begin
        ent_t e;
        bit   stall;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) tbl[i] = '0;
            m_redir = 0;
            m_flush = 0;
            m_pc    = 16'h0;
            m_cnt   = 16'h0;
        end else begin
            e = tbl[cmt_rob_index];
            if (br_valid && br_rob_index == cmt_rob_index) e = '{1'b1, br_taken, br_target};
            if (m_redir) stall = cmt_valid;
            else stall = cmt_valid && cmt_is_branch && !e.res;

            check("cmt_stall", 32'(cmt_stall), 32'(stall));
            check("flush", 32'(flush), 32'(m_flush));
            check("redirect_valid", 32'(redirect_valid), 32'(m_redir));
            check("redirect_pc", 32'(redirect_pc), 32'(m_pc));
            check("taken_count", 32'(taken_count), 32'(m_cnt));

            m_flush = 0;
            if (!m_redir) begin
                if (br_valid) tbl[br_rob_index] = '{1'b1, br_taken, br_target};
                if (cmt_valid && cmt_is_branch && e.res) begin
                    if (e.taken) begin
                        for (int i = 0; i < 16; i++) tbl[i] = '0;
                        m_redir = 1;
                        m_flush = 1;
                        m_pc    = e.tgt;
                        m_cnt   = m_cnt + 16'd1;
                    end else begin
                        tbl[cmt_rob_index].res = 1'b0;
                    end
                end
            end else if (redirect_ready) begin
                m_redir = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        br_valid       = 0;
        br_rob_index   = 0;
        br_target      = 0;
        br_taken       = 0;
        cmt_valid      = 0;
        cmt_rob_index  = 0;
        cmt_is_branch  = 0;
        redirect_ready = 0;
    endtask

    task automatic drive_br(input logic [3:0] idx, input logic tk, input logic [15:0] tgt);
        br_valid     = 1;
        br_rob_index = idx;
        br_taken     = tk;
        br_target    = tgt;
    endtask

    task automatic drive_cmt(input logic [3:0] idx);
        cmt_valid     = 1;
        cmt_is_branch = 1;
        cmt_rob_index = idx;
    endtask

    // Bypassed taken commit followed by immediate redirect acceptance
    task automatic taken_commit(input logic [15:0] tgt);
        drive_br(4'd9, 1'b1, tgt);
        drive_cmt(4'd9);
        tick();
        idle_inputs();
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
        #1;
        check("reset_count", 32'(taken_count), 32'h0);
        check("reset_rv", 32'(redirect_valid), 32'h0);
        check("reset_flush", 32'(flush), 32'h0);

        // 1: not-taken result then commit
        drive_br(4'd3, 1'b0, 16'h0100);
        tick();
        idle_inputs();
        drive_cmt(4'd3);
        #1;
        check("t1_stall", 32'(cmt_stall), 32'h0);
        tick();
        idle_inputs();
        #1;
        check("t1_noflush", 32'(flush), 32'h0);
        drive_cmt(4'd3);
        #1;
        check("t1_cleared", 32'(cmt_stall), 32'h1);
        tick();
        idle_inputs();

        // 2: unresolved commit waits, then bypassed taken result
        drive_cmt(4'd5);
        repeat (3) begin
            #1;
            check("t2_stall", 32'(cmt_stall), 32'h1);
            tick();
        end
        drive_br(4'd5, 1'b1, 16'h0040);
        #1;
        check("t2_bypass", 32'(cmt_stall), 32'h0);
        tick();
        idle_inputs();
        #1;
        check("t2_flush", 32'(flush), 32'h1);
        check("t2_pc", 32'(redirect_pc), 32'h0040);
        redirect_ready = 1;
        tick();
        redirect_ready = 0;

        // 3: held redirect with ready low
        drive_br(4'd1, 1'b1, 16'h1234);
        tick();
        idle_inputs();
        drive_cmt(4'd1);
        tick();
        drive_cmt(4'd4);
        repeat (4) tick();
        #1;
        check("t3_pc", 32'(redirect_pc), 32'h1234);
        check("t3_flush_once", 32'(flush), 32'h0);
        redirect_ready = 1;
        tick();
        idle_inputs();
        #1;
        check("t3_released", 32'(redirect_valid), 32'h0);

        // 4: result during REDIRECT is dropped
        drive_br(4'd6, 1'b1, 16'h2000);
        drive_cmt(4'd6);
        tick();
        idle_inputs();
        drive_br(4'd2, 1'b1, 16'h3000);
        tick();
        idle_inputs();
        redirect_ready = 1;
        tick();
        idle_inputs();
        drive_cmt(4'd2);
        #1;
        check("t4_dropped", 32'(cmt_stall), 32'h1);
        tick();
        idle_inputs();

        // 5: overwrite to not-taken wins
        drive_br(4'd7, 1'b1, 16'h0700);
        tick();
        drive_br(4'd7, 1'b0, 16'h0700);
        tick();
        idle_inputs();
        drive_cmt(4'd7);
        tick();
        idle_inputs();
        #1;
        check("t5_noflush", 32'(flush), 32'h0);

        // 6: counter wrap, then reset in REDIRECT
        force dut.taken_count_q = 16'hFFFE;
        #1;
        release dut.taken_count_q;
        m_cnt = 16'hFFFE;
        taken_commit(16'h0a00);
        taken_commit(16'h0b00);
        #1;
        check("t6_wrap", 32'(taken_count), 32'h0);
        drive_br(4'd9, 1'b1, 16'h0c00);
        drive_cmt(4'd9);
        tick();
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        check("t6_rst_rv", 32'(redirect_valid), 32'h0);
        check("t6_rst_flush", 32'(flush), 32'h0);
        drive_cmt(4'd9);
        #1;
        check("t6_empty", 32'(cmt_stall), 32'h1);
        tick();
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
